// File: rtl/bus_read_port.sv
// Registered source-select for the shared datapath bus, with a valid/ack capture stage.
// Optional multi-source checker built when BUS_CONFLICT_DETECT_EN is defined.
module bus_read_port #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_sel,
  input  logic                  req,
  input  logic                  ack,
  output logic [WIDTH-1:0]      BusMuxOut,
  output logic                  bus_valid,
  output logic [4:0]            sel_code,
  output logic                  conflict,
  output logic [7:0]            conflict_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic [WIDTH-1:0] r_bus;
  logic [4:0]       r_code;
  logic [WIDTH-1:0] w_data;
  logic [4:0]       w_idx;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_capture   = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (ack) begin
          w_capture   = req;
          w_state_nxt = req ? DRIVE : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Scan downward so the lowest set bit is the last one to assign.
  always_comb begin
    w_idx  = 5'd31;
    w_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_sel[i]) begin
        w_idx  = 5'(i);
        w_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_bus  <= '0;
      r_code <= '0;
    end else if (w_capture) begin
      r_bus  <= w_data;
      r_code <= w_idx;
    end
  end

  assign BusMuxOut = r_bus;
  assign sel_code  = r_code;
  assign bus_valid = (r_state == DRIVE);

`ifdef BUS_CONFLICT_DETECT_EN
  logic       w_multi;
  logic       r_conflict;
  logic [7:0] r_conflict_cnt;

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign w_multi = |(src_sel & (src_sel - {{(NSRC-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_conflict     <= 1'b0;
      r_conflict_cnt <= '0;
    end else if (w_capture && w_multi) begin
      r_conflict <= 1'b1;
      if (r_conflict_cnt != 8'hFF) begin
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
    end
  end

  assign conflict     = r_conflict;
  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict     = 1'b0;
  assign conflict_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bus_read_port.sv
// Directed bench for bus_read_port; conflict expectations follow BUS_CONFLICT_DETECT_EN.
`timescale 1ns/1ps
module tb_bus_read_port;
  localparam int WIDTH = 32;
  localparam int NSRC  = 24;

`ifdef BUS_CONFLICT_DETECT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic                  clk;
  logic                  clr;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_sel;
  logic                  req;
  logic                  ack;
  logic [WIDTH-1:0]      BusMuxOut;
  logic                  bus_valid;
  logic [4:0]            sel_code;
  logic                  conflict;
  logic [7:0]            conflict_cnt;

  int n_vec;
  int n_err;

  bus_read_port #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk          (clk),
    .clr          (clr),
    .src_data     (src_data),
    .src_sel      (src_sel),
    .req          (req),
    .ack          (ack),
    .BusMuxOut    (BusMuxOut),
    .bus_valid    (bus_valid),
    .sel_code     (sel_code),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [31:0] val);
    src_data[idx*WIDTH +: WIDTH] = val;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    clr      = 1'b1;
    src_data = '0;
    src_sel  = '0;
    req      = 1'b0;
    ack      = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    check("rst_bus",   BusMuxOut, 32'h0);
    check("rst_valid", 32'(bus_valid), 32'h0);
    check("rst_code",  32'(sel_code), 32'h0);
    check("rst_conf",  32'(conflict), 32'h0);
    check("rst_cnt",   32'(conflict_cnt), 32'h0);

    // ack while idle is ignored
    ack = 1'b1;
    tick();
    check("idle_ack_valid", 32'(bus_valid), 32'h0);
    ack = 1'b0;

    // single read of R5
    set_src(5, 32'h0000_00A5);
    src_sel = 24'(1) << 5;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("rd_bus",   BusMuxOut, 32'h0000_00A5);
    check("rd_code",  32'(sel_code), 32'd5);
    check("rd_valid", 32'(bus_valid), 32'h1);
    tick();
    check("rd_hold_valid", 32'(bus_valid), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("rel_valid", 32'(bus_valid), 32'h0);
    check("rel_bus",   BusMuxOut, 32'h0000_00A5);

    // back-to-back: PC, MDR, Zlow
    set_src(20, 32'h2000_0020);
    set_src(21, 32'h2100_0021);
    set_src(19, 32'h1900_0019);
    req = 1'b1;
    ack = 1'b1;
    src_sel = 24'(1) << 20;
    tick();
    check("b2b_pc",       BusMuxOut, 32'h2000_0020);
    check("b2b_pc_code",  32'(sel_code), 32'd20);
    check("b2b_pc_valid", 32'(bus_valid), 32'h1);
    src_sel = 24'(1) << 21;
    tick();
    check("b2b_mdr",       BusMuxOut, 32'h2100_0021);
    check("b2b_mdr_valid", 32'(bus_valid), 32'h1);
    src_sel = 24'(1) << 19;
    tick();
    check("b2b_zlo",       BusMuxOut, 32'h1900_0019);
    check("b2b_zlo_code",  32'(sel_code), 32'd19);
    check("b2b_zlo_valid", 32'(bus_valid), 32'h1);
    req = 1'b0;
    tick();
    ack = 1'b0;
    check("b2b_end_valid", 32'(bus_valid), 32'h0);

    // stall: changes while ack low must not reach the bus
    set_src(7, 32'h0000_0077);
    src_sel = 24'(1) << 7;
    req = 1'b1;
    tick();
    set_src(7, 32'h0000_0088);
    set_src(8, 32'h0000_0888);
    src_sel = 24'(1) << 8;
    tick();
    req = 1'b0;
    check("stall_bus",   BusMuxOut, 32'h0000_0077);
    check("stall_code",  32'(sel_code), 32'd7);
    check("stall_valid", 32'(bus_valid), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // conflict: R3 and HI both enabled, lowest wins
    set_src(3, 32'h0000_0003);
    set_src(16, 32'h0000_1600);
    src_sel = (24'(1) << 3) | (24'(1) << 16);
    req = 1'b1;
    tick();
    check("conf_bus",  BusMuxOut, 32'h3);
    check("conf_code", 32'(sel_code), 32'd3);
    check("conf_flag", 32'(conflict), 32'(CONF_EN));
    check("conf_cnt",  32'(conflict_cnt), CONF_EN ? 32'd1 : 32'd0);

    // no-select capture gives a valid zero word with code 31
    ack = 1'b1;
    src_sel = '0;
    tick();
    check("nosel_bus",   BusMuxOut, 32'h0);
    check("nosel_code",  32'(sel_code), 32'd31);
    check("nosel_valid", 32'(bus_valid), 32'h1);
    check("nosel_flag",  32'(conflict), 32'(CONF_EN));
    check("nosel_cnt",   32'(conflict_cnt), CONF_EN ? 32'd1 : 32'd0);

    // 300 more conflicting captures: 1 + 300 saturates at 255
    src_sel = (24'(1) << 3) | (24'(1) << 16);
    for (int k = 0; k < 300; k++) begin
      tick();
    end
    check("sat_cnt",  32'(conflict_cnt), CONF_EN ? 32'd255 : 32'd0);
    check("sat_flag", 32'(conflict), 32'(CONF_EN));
    check("sat_valid", 32'(bus_valid), 32'h1);

    // reset in the same cycle as a req while driving
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req = 1'b0;
    ack = 1'b0;
    check("mid_rst_valid", 32'(bus_valid), 32'h0);
    check("mid_rst_bus",   BusMuxOut, 32'h0);
    check("mid_rst_code",  32'(sel_code), 32'h0);
    check("mid_rst_conf",  32'(conflict), 32'h0);
    check("mid_rst_cnt",   32'(conflict_cnt), 32'h0);
    tick();
    check("post_rst_valid", 32'(bus_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
